// File: rtl/epu_dma_pkg.sv
// Shared types and constants for the EPU DMA master: FSM state encoding, AXI burst/size/resp codes
// and the burst-length helper used when each new burst is issued.
`ifndef AXI_ID_BITS
`define AXI_ID_BITS 4
`endif
package epu_dma_pkg;

   typedef enum logic [2:0] {
      IDLE,
      RD_ADDR,
      RD_DATA,
      WR_ADDR,
      WR_DATA,
      WR_RESP,
      FINISH
   } dma_state_e;

   localparam logic [1:0] INCR    = 2'b01;
   localparam logic [2:0] SIZE_4B = 3'b010;
   localparam logic [1:0] OKAY    = 2'b00;
   localparam logic [1:0] SLVERR  = 2'b10;

   localparam int DEF_BURST_MAX = 16;

   // Beats for the next burst: limited by words left, the burst cap and the room before the next
   // 1 KB boundary on both the source and the destination side.
   function automatic logic [4:0] burst_beats(input logic [31:0] src, input logic [31:0] dst,
                                              input logic [15:0] remaining, input logic [4:0] burst_max);
      logic [8:0]  src_room;
      logic [8:0]  dst_room;
      logic [16:0] beats;
      src_room = 9'd256 - {1'b0, src[9:2]};
      dst_room = 9'd256 - {1'b0, dst[9:2]};
      beats    = {1'b0, remaining};
      if (beats > {12'd0, burst_max}) beats = {12'd0, burst_max};
      if (beats > {8'd0, src_room})   beats = {8'd0, src_room};
      if (beats > {8'd0, dst_room})   beats = {8'd0, dst_room};
      return beats[4:0];
   endfunction

endpackage

// File: rtl/epu_dma_buf.sv
// Word buffer holding one burst between its read and write phases; pointers and count are
// cleared at the start of every burst.
module epu_dma_buf #(
   parameter  int BUF_DEPTH = 16,
   localparam int PW        = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        clr,
   input  logic        wr_en,
   input  logic [31:0] wr_data,
   input  logic        rd_en,
   output logic [31:0] rd_data,
   output logic [PW:0] count
);

   logic [31:0]   mem [BUF_DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (clr) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_en) wr_ptr <= ptr_inc(wr_ptr);
         if (rd_en) rd_ptr <= ptr_inc(rd_ptr);
         case ({wr_en, rd_en})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // NOTE: the storage array is deliberately left without reset; every word is written before it
   // is read, so resetting it would only cost flops and routing.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr] <= wr_data;
   end

   assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/epu_dma_master.sv
// AXI4 DMA master copying len_words words from src_addr to dst_addr, one burst buffered at a time.
// Defining EPU_DMA_IRQ_EN adds a sticky irq output raised on completion.
`ifndef AXI_ID_BITS
`define AXI_ID_BITS 4
`endif
module epu_dma_master
   import epu_dma_pkg::*;
#(
   parameter int BURST_MAX = DEF_BURST_MAX,
   parameter int BUF_DEPTH = 16
) (
   input  logic                    CLK,
   input  logic                    RSTn,
   input  logic                    start,
   input  logic [31:0]             src_addr,
   input  logic [31:0]             dst_addr,
   input  logic [15:0]             len_words,
   output logic                    busy,
   output logic                    done,
   output logic                    err,
   output logic [`AXI_ID_BITS-1:0] ARID_M,
   output logic [31:0]             ARADDR_M,
   output logic [3:0]              ARLEN_M,
   output logic [2:0]              ARSIZE_M,
   output logic [1:0]              ARBURST_M,
   output logic                    ARVALID_M,
   input  logic                    ARREADY_M,
   input  logic [`AXI_ID_BITS-1:0] RID_M,
   input  logic [31:0]             RDATA_M,
   input  logic [1:0]              RRESP_M,
   input  logic                    RLAST_M,
   input  logic                    RVALID_M,
   output logic                    RREADY_M,
   output logic [`AXI_ID_BITS-1:0] AWID_M,
   output logic [31:0]             AWADDR_M,
   output logic [3:0]              AWLEN_M,
   output logic [2:0]              AWSIZE_M,
   output logic [1:0]              AWBURST_M,
   output logic                    AWVALID_M,
   input  logic                    AWREADY_M,
   output logic [31:0]             WDATA_M,
   output logic [3:0]              WSTRB_M,
   output logic                    WLAST_M,
   output logic                    WVALID_M,
   input  logic                    WREADY_M,
   input  logic [`AXI_ID_BITS-1:0] BID_M,
   input  logic [1:0]              BRESP_M,
   input  logic                    BVALID_M,
   output logic                    BREADY_M
`ifdef EPU_DMA_IRQ_EN
   ,
   output logic                    irq
`endif
);

   localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;

   dma_state_e  state;
   logic [31:0] src;
   logic [31:0] dst;
   logic [15:0] remaining;
   logic [4:0]  beats;

   logic        r_hs, w_hs, b_hs;
   logic        buf_clr;
   logic [31:0] buf_data;
   logic [PW:0] buf_count;
   logic [31:0] src_next, dst_next;
   logic [15:0] rem_next;

   assign r_hs     = RVALID_M && RREADY_M;
   assign w_hs     = WVALID_M && WREADY_M;
   assign b_hs     = BVALID_M && BREADY_M;
   assign buf_clr  = (state == RD_ADDR);
   assign src_next = src + {25'd0, beats, 2'b00};
   assign dst_next = dst + {25'd0, beats, 2'b00};
   assign rem_next = remaining - {11'd0, beats};

   // Single outstanding transaction, so response IDs carry no information.
   logic unused_ids;
   assign unused_ids = ^{RID_M, BID_M};

   assign ARID_M    = '0;
   assign ARADDR_M  = src;
   assign ARLEN_M   = 4'(beats - 5'd1);
   assign ARSIZE_M  = SIZE_4B;
   assign ARBURST_M = INCR;
   assign AWID_M    = '0;
   assign AWADDR_M  = dst;
   assign AWLEN_M   = 4'(beats - 5'd1);
   assign AWSIZE_M  = SIZE_4B;
   assign AWBURST_M = INCR;
   assign WDATA_M   = buf_data;
   assign WSTRB_M   = 4'hF;

   epu_dma_buf #(.BUF_DEPTH(BUF_DEPTH)) u_buf (
      .clk     (CLK),
      .rst_n   (RSTn),
      .clr     (buf_clr),
      .wr_en   (r_hs),
      .wr_data (RDATA_M),
      .rd_en   (w_hs),
      .rd_data (buf_data),
      .count   (buf_count)
   );

   // NOTE: all state and every VALID/READY/status output update with non-blocking assignments in
   // this one clocked block, so no READY input can reach a VALID output combinationally.
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         state     <= IDLE;
         src       <= '0;
         dst       <= '0;
         remaining <= '0;
         beats     <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
         ARVALID_M <= 1'b0;
         RREADY_M  <= 1'b0;
         AWVALID_M <= 1'b0;
         WVALID_M  <= 1'b0;
         WLAST_M   <= 1'b0;
         BREADY_M  <= 1'b0;
`ifdef EPU_DMA_IRQ_EN
         irq       <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: if (start) begin
               err  <= 1'b0;
               busy <= 1'b1;
`ifdef EPU_DMA_IRQ_EN
               irq  <= 1'b0;
`endif
               if (len_words != 16'd0) begin
                  src       <= src_addr;
                  dst       <= dst_addr;
                  remaining <= len_words;
                  beats     <= burst_beats(src_addr, dst_addr, len_words, 5'(BURST_MAX));
                  ARVALID_M <= 1'b1;
                  state     <= RD_ADDR;
               end else begin
                  done  <= 1'b1;
                  state <= FINISH;
               end
            end
            RD_ADDR: if (ARREADY_M) begin
               ARVALID_M <= 1'b0;
               RREADY_M  <= 1'b1;
               state     <= RD_DATA;
            end
            RD_DATA: if (r_hs) begin
               if (RRESP_M != OKAY) err <= 1'b1;
               if (RLAST_M) begin
                  RREADY_M  <= 1'b0;
                  AWVALID_M <= 1'b1;
                  state     <= WR_ADDR;
               end
            end
            WR_ADDR: if (AWREADY_M) begin
               AWVALID_M <= 1'b0;
               WVALID_M  <= 1'b1;
               WLAST_M   <= (beats == 5'd1);
               state     <= WR_DATA;
            end
            WR_DATA: if (w_hs) begin
               if (WLAST_M) begin
                  WVALID_M <= 1'b0;
                  WLAST_M  <= 1'b0;
                  BREADY_M <= 1'b1;
                  state    <= WR_RESP;
               end else begin
                  // Two words left before this beat leaves means the next beat is the last.
                  WLAST_M <= (buf_count == (PW + 1)'(2));
               end
            end
            WR_RESP: if (b_hs) begin
               BREADY_M  <= 1'b0;
               src       <= src_next;
               dst       <= dst_next;
               remaining <= rem_next;
               if (err || (BRESP_M != OKAY) || (rem_next == 16'd0)) begin
                  if (BRESP_M != OKAY) err <= 1'b1;
                  done  <= 1'b1;
                  state <= FINISH;
               end else begin
                  beats     <= burst_beats(src_next, dst_next, rem_next, 5'(BURST_MAX));
                  ARVALID_M <= 1'b1;
                  state     <= RD_ADDR;
               end
            end
            FINISH: begin
               done  <= 1'b0;
               busy  <= 1'b0;
`ifdef EPU_DMA_IRQ_EN
               irq   <= 1'b1;
`endif
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
